// File: rtl/quad_filter_decoder_pkg.sv
// Shared types and constants for the quadrature filter/decoder.
// Holds the FSM state enum, direction encoding and the CW Gray sequence.
package quad_pkg;

  typedef enum logic {ST_INIT, ST_TRACK} state_e;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // {A,B} clockwise sequence: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] GRAY_0 = 2'b00;
  localparam logic [1:0] GRAY_1 = 2'b01;
  localparam logic [1:0] GRAY_2 = 2'b11;
  localparam logic [1:0] GRAY_3 = 2'b10;

  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    case (ab)
      GRAY_0:  cw_next = GRAY_1;
      GRAY_1:  cw_next = GRAY_2;
      GRAY_2:  cw_next = GRAY_3;
      default: cw_next = GRAY_0;
    endcase
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Single-channel stability filter: output follows the synchronised input only
// after FILTER_CYCLES consecutive differing samples; load forces an immediate copy.
module quad_glitch_filter #(
  parameter int FILTER_CYCLES = 16,
  parameter int FILTER_W      = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sync_in,
  input  logic load,
  output logic filt
);

  logic [FILTER_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      filt <= sync_in;
    end else if (sync_in != filt) begin
      if (cnt == FILTER_W'(FILTER_CYCLES - 1)) begin
        cnt  <= '0;
        filt <= sync_in;
      end else begin
        cnt <= cnt + FILTER_W'(1);
      end
    end else begin
      // any return to the filtered level restarts the count
      cnt <= '0;
    end
  end

endmodule

// File: rtl/quad_filter_decoder.sv
// Synchronise, glitch-filter and Gray-decode rotary encoder contacts into turned/direction strobes.
// Optional QUAD_ERR_COUNT_EN adds a saturating illegal-transition counter on err_count.
module quad_filter_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int FILTER_W      = 8
`ifdef QUAD_ERR_COUNT_EN
  , parameter int ERR_W       = 8
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rotary_a,
  input  logic rotary_b,
  output logic turned,
  output logic direction,
  output logic err
`ifdef QUAD_ERR_COUNT_EN
  , output logic [ERR_W-1:0] err_count
`endif
);

  logic [1:0] meta_q, sync_q, sync_prev_q;
  logic [1:0] cur_ab, prev_ab, prev_ab_d;
  logic [FILTER_W-1:0] settle_q, settle_d;
  state_e state_q, state_d;
  logic load, turned_d, dir_d, err_d;

  // 2-flop synchroniser per channel, bit 1 = A, bit 0 = B
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
    end else begin
      meta_q      <= {rotary_a, rotary_b};
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
    end
  end

  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES), .FILTER_W(FILTER_W)) u_filt_a (
    .clock(clock), .reset_n(reset_n), .sync_in(sync_q[1]), .load(load), .filt(cur_ab[1])
  );
  quad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES), .FILTER_W(FILTER_W)) u_filt_b (
    .clock(clock), .reset_n(reset_n), .sync_in(sync_q[0]), .load(load), .filt(cur_ab[0])
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      settle_q  <= '0;
      prev_ab   <= '0;
      turned    <= 1'b0;
      direction <= DIR_CW;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      prev_ab   <= prev_ab_d;
      turned    <= turned_d;
      direction <= dir_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    prev_ab_d = prev_ab;
    load      = 1'b0;
    turned_d  = 1'b0;
    dir_d     = direction;
    err_d     = 1'b0;
    case (state_q)
      ST_INIT: begin
        // adopt the resting position silently once the contacts have settled
        if (sync_q == sync_prev_q) begin
          if (settle_q == FILTER_W'(FILTER_CYCLES - 1)) begin
            load      = 1'b1;
            prev_ab_d = sync_q;
            settle_d  = '0;
            state_d   = ST_TRACK;
          end else begin
            settle_d = settle_q + FILTER_W'(1);
          end
        end else begin
          settle_d = '0;
        end
      end
      default: begin
        prev_ab_d = cur_ab;
        if (cur_ab != prev_ab) begin
          if (cur_ab == cw_next(prev_ab)) begin
            turned_d = 1'b1;
            dir_d    = DIR_CW;
          end else if (prev_ab == cw_next(cur_ab)) begin
            turned_d = 1'b1;
            dir_d    = DIR_CCW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

`ifdef QUAD_ERR_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_count <= '0;
    else if (err_d && (err_count != {ERR_W{1'b1}}))
      err_count <= err_count + ERR_W'(1);
  end
`endif

endmodule

// File: tb/tb_quad_filter_decoder.sv
// Directed self-checking bench for quad_filter_decoder at FILTER_CYCLES=4.
// Turned/err are expected 7 edges after a raw change (sampling edge counts as 1).
module tb_quad_filter_decoder;
  import quad_pkg::*;

  localparam int FC  = 4;
  localparam int LAT = FC + 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rotary_a = 1'b1, rotary_b = 1'b1;
  logic turned, direction, err;
`ifdef QUAD_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  quad_filter_decoder #(
    .FILTER_CYCLES(FC), .FILTER_W(8)
`ifdef QUAD_ERR_COUNT_EN
    , .ERR_W(8)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .rotary_a(rotary_a), .rotary_b(rotary_b),
    .turned(turned), .direction(direction), .err(err)
`ifdef QUAD_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int turn_cnt = 0, err_cnt = 0, last_turn_cyc = -1, last_err_cyc = -1;
  logic last_dir = 1'b0;
  int n_chk = 0, n_pass = 0;
  int chg, base_t, base_e;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (turned) begin
      turn_cnt      = turn_cnt + 1;
      last_turn_cyc = cyc;
      last_dir      = direction;
    end
    if (err) begin
      err_cnt      = err_cnt + 1;
      last_err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic a, input logic b, input int hold);
    @(negedge clock);
    rotary_a = a;
    rotary_b = b;
    chg = cyc;
    repeat (hold) @(negedge clock);
  endtask

  initial begin
    // reset with encoder resting at 11
    repeat (3) @(negedge clock);
    chk("rst_turned", turned, 0);
    chk("rst_dir", direction, 0);
    chk("rst_err", err, 0);
`ifdef QUAD_ERR_COUNT_EN
    chk("rst_err_count", err_count, 0);
`endif
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("init_prev_ab", dut.prev_ab, 3);
    chk("init_no_turn", turn_cnt, 0);
    chk("init_no_err", err_cnt, 0);

    // clockwise lap from 11: 10, 00, 01, 11
    step(1, 0, 20); chk("cw1_lat", last_turn_cyc, chg + LAT); chk("cw1_dir", last_dir, DIR_CW);
    step(0, 0, 20); chk("cw2_lat", last_turn_cyc, chg + LAT); chk("cw2_dir", last_dir, DIR_CW);
    step(0, 1, 20); chk("cw3_lat", last_turn_cyc, chg + LAT); chk("cw3_dir", last_dir, DIR_CW);
    step(1, 1, 20); chk("cw4_lat", last_turn_cyc, chg + LAT); chk("cw4_dir", last_dir, DIR_CW);
    chk("cw_count", turn_cnt, 4);
    chk("cw_no_err", err_cnt, 0);

    // counter-clockwise lap from 11: 01, 00, 10, 11
    step(0, 1, 20); chk("ccw1_lat", last_turn_cyc, chg + LAT); chk("ccw1_dir", last_dir, DIR_CCW);
    step(0, 0, 20); chk("ccw2_lat", last_turn_cyc, chg + LAT); chk("ccw2_dir", last_dir, DIR_CCW);
    step(1, 0, 20); chk("ccw3_lat", last_turn_cyc, chg + LAT); chk("ccw3_dir", last_dir, DIR_CCW);
    step(1, 1, 20); chk("ccw4_lat", last_turn_cyc, chg + LAT); chk("ccw4_dir", last_dir, DIR_CCW);
    chk("ccw_count", turn_cnt, 8);
    chk("ccw_no_err", err_cnt, 0);

    // move to 01, then bounce A every 2 cycles before settling at 1
    step(0, 1, 20);
    chk("pre_bounce_count", turn_cnt, 9);
    base_t = turn_cnt;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      rotary_a = ~rotary_a;
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    chk("bounce_no_turn", turn_cnt, base_t);
    step(1, 1, 20);
    chk("bounce_settle_count", turn_cnt, base_t + 1);
    chk("bounce_settle_lat", last_turn_cyc, chg + LAT);
    chk("bounce_settle_dir", last_dir, DIR_CW);

    // both channels together: illegal
    base_t = turn_cnt;
    base_e = err_cnt;
    step(0, 0, 20);
    chk("err_once", err_cnt, base_e + 1);
    chk("err_lat", last_err_cyc, chg + LAT);
    chk("err_no_turn", turn_cnt, base_t);
`ifdef QUAD_ERR_COUNT_EN
    chk("err_count_1", err_count, 1);
`endif
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) step(1, 1, 10);
      else            step(0, 0, 10);
    end
    chk("err_many", err_cnt, base_e + 301);
    chk("err_many_no_turn", turn_cnt, base_t);
`ifdef QUAD_ERR_COUNT_EN
    chk("err_count_sat", err_count, 255);
`endif

    // at 00: step CW to 01 and reset while the strobe is high
    @(negedge clock);
    rotary_a = 1'b0;
    rotary_b = 1'b1;
    chg = cyc;
    repeat (LAT) @(negedge clock);
    chk("pre_rst_turned", turned, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_turned", turned, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_dir", direction, 0);
`ifdef QUAD_ERR_COUNT_EN
    chk("mid_rst_err_count", err_count, 0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    base_t = turn_cnt;
    base_e = err_cnt;
    repeat (40) @(negedge clock);
    chk("post_rst_no_turn", turn_cnt, base_t);
    chk("post_rst_no_err", err_cnt, base_e);
    step(1, 1, 20);
    chk("post_rst_turn", turn_cnt, base_t + 1);
    chk("post_rst_lat", last_turn_cyc, chg + LAT);
    chk("post_rst_dir", last_dir, DIR_CW);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
